// File: rtl/ofifo_drain_pkg.sv
// Shared types for the output-side psum buffer bank.
// Holds the drain FSM state encoding.
package ofifo_drain_pkg;

   localparam int DRAIN_ST_BW = 2;

   typedef enum logic [DRAIN_ST_BW-1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column synchronous FIFO for one MAC column's psums.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module ofifo_col_fifo #(
   parameter int psum_bw = 16,
   parameter int depth   = 64,
   parameter int ptr_bw  = $clog2(depth),
   parameter int cnt_bw  = ptr_bw + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_wr,
   input  logic [psum_bw-1:0] i_data,
   input  logic               i_rd,
   output logic [psum_bw-1:0] o_data,
   output logic               o_empty,
   output logic               o_full,
   output logic               o_drop
);

   logic [psum_bw-1:0] r_mem [depth];
   logic [ptr_bw-1:0]  r_wr_ptr;
   logic [ptr_bw-1:0]  r_rd_ptr;
   logic [cnt_bw-1:0]  r_count;

   logic w_pop;
   logic w_push;

   assign o_empty = (r_count == cnt_bw'(0));
   assign o_full  = (r_count == cnt_bw'(depth));
   assign w_pop   = i_rd && !o_empty;
   assign w_push  = i_wr && (!o_full || w_pop);
   assign o_drop  = i_wr && !w_push;
   assign o_data  = r_mem[r_rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ptr_bw'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ptr_bw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + cnt_bw'(1);
            2'b01:   r_count <= r_count - cnt_bw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ofifo_drain.sv
// Output psum buffer bank: one FIFO per column, row-aligned pops,
// and an autonomous drain FSM that pops a requested number of rows.
module ofifo_drain
   import ofifo_drain_pkg::*;
#(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64,
   localparam int ptr_bw = $clog2(depth),
   localparam int cnt_bw = ptr_bw + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*psum_bw-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   input  logic                   drain_start,
   input  logic [cnt_bw-1:0]      drain_len,
   output logic [col*psum_bw-1:0] out,
   output logic                   out_valid,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow,
   output logic                   drain_busy,
   output logic                   drain_done
);

   drain_state_e r_state;
   drain_state_e w_state_nxt;
   logic [cnt_bw-1:0] r_remaining;
   logic [cnt_bw-1:0] w_remaining_nxt;

   logic [col-1:0]         w_empty;
   logic [col-1:0]         w_full;
   logic [col-1:0]         w_drop;
   logic [col*psum_bw-1:0] w_row;
   logic                   w_pop;

   for (genvar c = 0; c < col; c++) begin : g_col
      ofifo_col_fifo #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_wr    (wr[c]),
         .i_data  (in[psum_bw*c +: psum_bw]),
         .i_rd    (w_pop),
         .o_data  (w_row[psum_bw*c +: psum_bw]),
         .o_empty (w_empty[c]),
         .o_full  (w_full[c]),
         .o_drop  (w_drop[c])
      );
   end

   // A row exists only when every column holds at least one word.
   assign o_valid    = ~|w_empty;
   assign o_full     = |w_full;
   assign o_ready    = ~o_full;
   assign w_pop      = o_valid && ((r_state == ST_DRAIN) || rd);
   assign drain_busy = (r_state == ST_DRAIN);
   assign drain_done = (r_state == ST_DONE);

   // Registered row output and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         out        <= '0;
         out_valid  <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         out_valid <= w_pop;
         if (w_pop) begin
            out <= w_row;
         end
         if (|w_drop) begin
            o_overflow <= 1'b1;
         end
      end
   end

   // Drain FSM state and remaining-row counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   // Drain FSM next state; DRAIN waits indefinitely for a poppable row.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      case (r_state)
         ST_IDLE: begin
            if (drain_start) begin
               w_remaining_nxt = drain_len;
               if (drain_len == cnt_bw'(0)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (w_pop) begin
               w_remaining_nxt = r_remaining - cnt_bw'(1);
               if (r_remaining == cnt_bw'(1)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_ofifo_drain.sv
// Scoreboard bench for ofifo_drain: expected rows are queued at stimulus time
// and a negedge monitor compares each out_valid row against the queue head.
module tb_ofifo_drain;

   logic         clk;
   logic         reset;
   logic [127:0] din;
   logic [7:0]   wr;
   logic         rd;
   logic         drain_start;
   logic [6:0]   drain_len;
   logic [127:0] out_row;
   logic         out_valid;
   logic         o_valid;
   logic         o_full;
   logic         o_ready;
   logic         o_overflow;
   logic         drain_busy;
   logic         drain_done;

   int tests_run = 0;
   int failed    = 0;
   logic [127:0] exp_q [$];
   logic [127:0] exp_row;

   ofifo_drain dut (
      .clk         (clk),
      .reset       (reset),
      .in          (din),
      .wr          (wr),
      .rd          (rd),
      .drain_start (drain_start),
      .drain_len   (drain_len),
      .out         (out_row),
      .out_valid   (out_valid),
      .o_valid     (o_valid),
      .o_full      (o_full),
      .o_ready     (o_ready),
      .o_overflow  (o_overflow),
      .drain_busy  (drain_busy),
      .drain_done  (drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      tests_run++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_row(input int base, input int step);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) r[16*c +: 16] = 16'(base + c*step);
      return r;
   endfunction

   task automatic write_row(input logic [7:0] mask, input logic [127:0] row);
      wr  = mask;
      din = row;
      tick();
      wr  = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr = 8'h00; rd = 1'b0; drain_start = 1'b0; drain_len = 7'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every presented row must match the oldest expected row.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_row: got %0h required no row", out_row);
         end else begin
            exp_row = exp_q.pop_front();
            if (out_row !== exp_row) begin
               failed++;
               $display("FAIL row_data: got %0h required %0h", out_row, exp_row);
            end
         end
      end
   end

   initial begin
      logic [127:0] r;
      int busy_n, done_n, ov_n;
      din = '0;
      do_reset();

      // 1: reset state, partial fill, single rd pop
      chk("rst_out_valid", out_valid, 0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_full", o_full, 0);
      chk("rst_o_ready", o_ready, 1);
      chk("rst_overflow", o_overflow, 0);
      chk("rst_busy", drain_busy, 0);
      chk("rst_done", drain_done, 0);
      chk("rst_out", out_row, 0);
      write_row(8'h7F, mk_row(100, 1));
      chk("t1_partial_o_valid", o_valid, 0);
      write_row(8'h80, mk_row(100, 1));
      chk("t1_full_row_o_valid", o_valid, 1);
      exp_q.push_back(mk_row(100, 1));
      rd = 1'b1;
      tick();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_o_valid_after", o_valid, 0);
      tick();
      rd = 1'b0;
      chk("t1_rd_empty_no_pop", out_valid, 0);
      chk("t1_out_hold", out_row, mk_row(100, 1));

      // 2: skewed fill, column c starts at cycle c
      do_reset();
      for (int t = 0; t < 11; t++) begin
         logic [7:0] m;
         m = 8'h00;
         r = '0;
         for (int c = 0; c < 8; c++) begin
            if (t >= c && t < c + 4) begin
               m[c] = 1'b1;
               r[16*c +: 16] = 16'(c*16 + (t - c));
            end
         end
         write_row(m, r);
      end
      chk("t2_o_valid", o_valid, 1);
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_row(i, 16));
      rd = 1'b1;
      repeat (4) tick();
      rd = 1'b0;
      chk("t2_drained", o_valid, 0);
      tick();

      // 3: fill col3, overflow, push+pop while full
      do_reset();
      for (int i = 0; i < 64; i++) begin
         r = '0;
         r[48 +: 16] = 16'(i);
         write_row(8'h08, r);
      end
      chk("t3_o_full", o_full, 1);
      chk("t3_o_ready", o_ready, 0);
      chk("t3_no_overflow_yet", o_overflow, 0);
      r = '0;
      r[48 +: 16] = 16'd999;
      write_row(8'h08, r);
      chk("t3_overflow", o_overflow, 1);
      write_row(8'hF7, mk_row(500, 1));
      chk("t3_row_ready", o_valid, 1);
      r = mk_row(500, 1);
      r[48 +: 16] = 16'd0;
      exp_q.push_back(r);
      r[48 +: 16] = 16'd777;
      wr = 8'h08; din = r; rd = 1'b1;
      tick();
      wr = 8'h00; rd = 1'b0;
      chk("t3_full_after_pushpop", o_full, 1);
      chk("t3_others_empty", o_valid, 0);
      chk("t3_overflow_sticky", o_overflow, 1);
      tick();

      // 4: drain 10 of 12 rows, rd toggled mid-drain
      do_reset();
      for (int i = 0; i < 12; i++) begin
         write_row(8'hFF, mk_row(200 + i*8, 1));
         exp_q.push_back(mk_row(200 + i*8, 1));
      end
      busy_n = 0; done_n = 0; ov_n = 0;
      drain_len = 7'd10;
      for (int i = 0; i < 14; i++) begin
         drain_start = (i == 0);
         rd = (i >= 2 && i < 7);
         tick();
         busy_n += int'(drain_busy);
         done_n += int'(drain_done);
         ov_n   += int'(out_valid);
      end
      drain_start = 1'b0; rd = 1'b0;
      chk("t4_busy_cycles", busy_n, 10);
      chk("t4_done_pulses", done_n, 1);
      chk("t4_pops", ov_n, 10);
      chk("t4_rows_left", o_valid, 1);
      rd = 1'b1;
      repeat (2) tick();
      rd = 1'b0;
      chk("t4_empty", o_valid, 0);
      tick();

      // 5: drain stalls on missing rows, then completes; zero-length drain
      do_reset();
      for (int i = 0; i < 2; i++) begin
         write_row(8'hFF, mk_row(300 + i*8, 1));
         exp_q.push_back(mk_row(300 + i*8, 1));
      end
      ov_n = 0; done_n = 0;
      drain_len = 7'd5;
      for (int i = 0; i < 6; i++) begin
         drain_start = (i == 0);
         tick();
         ov_n += int'(out_valid);
         done_n += int'(drain_done);
      end
      drain_start = 1'b0;
      chk("t5_stall_pops", ov_n, 2);
      chk("t5_stall_busy", drain_busy, 1);
      chk("t5_stall_no_done", done_n, 0);
      ov_n = 0;
      for (int i = 2; i < 5; i++) begin
         exp_q.push_back(mk_row(300 + i*8, 1));
         write_row(8'hFF, mk_row(300 + i*8, 1));
         ov_n += int'(out_valid);
         done_n += int'(drain_done);
      end
      for (int i = 0; i < 10 && done_n == 0; i++) begin
         tick();
         ov_n += int'(out_valid);
         done_n += int'(drain_done);
      end
      chk("t5_resume_pops", ov_n, 3);
      chk("t5_done", done_n, 1);
      chk("t5_busy_clear", drain_busy, 0);
      tick();
      write_row(8'hFF, mk_row(400, 1));
      done_n = 0; ov_n = 0;
      drain_len = 7'd0;
      for (int i = 0; i < 3; i++) begin
         drain_start = (i == 0);
         tick();
         done_n += int'(drain_done);
         ov_n   += int'(out_valid);
      end
      drain_start = 1'b0;
      chk("t5_len0_done", done_n, 1);
      chk("t5_len0_no_pop", ov_n, 0);
      chk("t5_len0_row_kept", o_valid, 1);

      // 6: reset in the middle of a drain with overflow set
      do_reset();
      for (int i = 0; i < 65; i++) begin
         r = '0;
         r[15:0] = 16'(i);
         write_row(8'h01, r);
      end
      for (int i = 0; i < 3; i++) write_row(8'hFE, mk_row(600, 1));
      chk("t6_overflow_set", o_overflow, 1);
      r = mk_row(600, 1);
      r[15:0] = 16'd0;
      exp_q.push_back(r);
      drain_len = 7'd3;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_o_valid", o_valid, 0);
      chk("t6_busy", drain_busy, 0);
      chk("t6_overflow", o_overflow, 0);
      chk("t6_o_full", o_full, 0);
      tick();
      tick();
      chk("sb_all_rows_seen", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
